// File: rtl/ast_pkg.sv
// Shared types and defaults for the AST alert source.
//   ast_alert_src_state_e : alert handshake FSM states
//   DebounceCntDefault    : default number of qualifying cycles
package ast_pkg;

  localparam int unsigned DebounceCntDefault = 3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAssert  = 2'd1,
    StAckWait = 2'd2
  } ast_alert_src_state_e;

endpackage

// File: rtl/ast_alert_debounce.sv
// Debounce qualifier for the alert source.
// Counts consecutive cycles with src_i high, saturating at DebounceCnt, and
// clears on any low cycle. qual_o is a registered flag, high while the count
// sits at DebounceCnt.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   src_i  : combined event/trigger source
//   qual_o : source has been high for DebounceCnt consecutive cycles
module ast_alert_debounce import ast_pkg::*; #(
  parameter int unsigned DebounceCnt = DebounceCntDefault
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic src_i,
  output logic qual_o
);

  localparam logic [3:0] CntMax = 4'(DebounceCnt);

  logic [3:0] cnt_d, cnt_q;
  logic       qual_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!src_i) begin
      cnt_d = 4'd0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // qual is computed from the next count so it flags in the same cycle the
  // counter reaches its target.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= 4'd0;
      qual_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      qual_q <= (cnt_d == CntMax);
    end
  end

  assign qual_o = qual_q;

endmodule

// File: rtl/ast_alert_src.sv
// AST alert source: debounces a sensor event / differential test trigger and
// raises a differential alert, held until acknowledged over a differential ack.
// Build option: define AST_ALERT_SRC_SKEW_EN to make alert_n_o lag alert_p_o
// by one cycle on every transition; otherwise both rails switch together.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   event_i            : raw sensor event (synchronous)
//   trig_p_i, trig_n_i : differential test trigger (either rail triggers)
//   ack_p_i, ack_n_i   : differential acknowledge (either rail acks)
//   alert_p_o/alert_n_o: differential alert request, flop outputs
//   busy_o             : handshake in progress
//   event_cnt_o        : saturating count of alerts raised
module ast_alert_src import ast_pkg::*; #(
  parameter int unsigned DebounceCnt = DebounceCntDefault,
  parameter int unsigned CntW        = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            event_i,
  input  logic            trig_p_i,
  input  logic            trig_n_i,
  input  logic            ack_p_i,
  input  logic            ack_n_i,
  output logic            alert_p_o,
  output logic            alert_n_o,
  output logic            busy_o,
  output logic [CntW-1:0] event_cnt_o
);

  localparam logic [CntW-1:0] CntSat = {CntW{1'b1}};

  logic trig_act, ack_act, src, qual, raise;

  ast_alert_src_state_e state_d, state_q;
  logic [CntW-1:0]      event_cnt_d, event_cnt_q;
  logic                 alert_p_q, alert_n_q;

  // A single stuck or broken rail must still trigger / acknowledge.
  assign trig_act = trig_p_i | ~trig_n_i;
  assign ack_act  = ack_p_i | ~ack_n_i;
  assign src      = event_i | trig_act;

  ast_alert_debounce #(
    .DebounceCnt(DebounceCnt)
  ) u_debounce (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .src_i (src),
    .qual_o(qual)
  );

  // Qualified events outside Idle are merged into the current alert.
  always_comb begin
    state_d = state_q;
    raise   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (qual) begin
          state_d = StAssert;
          raise   = 1'b1;
        end
      end
      StAssert: begin
        if (ack_act) state_d = StAckWait;
      end
      StAckWait: begin
        if (!ack_act) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    event_cnt_d = event_cnt_q;
    if (raise && (event_cnt_q != CntSat)) begin
      event_cnt_d = event_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      event_cnt_q <= '0;
      alert_p_q   <= 1'b0;
      alert_n_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      event_cnt_q <= event_cnt_d;
      alert_p_q   <= (state_d == StAssert);
`ifdef AST_ALERT_SRC_SKEW_EN
      alert_n_q   <= ~alert_p_q;
`else
      alert_n_q   <= (state_d != StAssert);
`endif
    end
  end

  assign alert_p_o   = alert_p_q;
  assign alert_n_o   = alert_n_q;
  assign busy_o      = (state_q != StIdle);
  assign event_cnt_o = event_cnt_q;

endmodule

// File: doc/ast_alert_src.md
AST_ALERT_SRC -- requirements
Module: ast_alert_src

Interface
REQ-001 SHALL provide parameter DebounceCnt, default 3, number of consecutive cycles a source must be high to qualify (legal 1..15).
REQ-002 SHALL provide parameter CntW, default 8, width of the raised-alert counter.
REQ-003 SHALL run on one clock; reset is synchronous and active-high.
REQ-004 clk_i  in  1  sole clock.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 event_i  in  1  raw sensor event, already synchronous to clk_i.
REQ-007 trig_p_i, trig_n_i  in  1 each  differential test-trigger pair from sensor control.
REQ-008 ack_p_i, ack_n_i  in  1 each  differential alert acknowledge pair from sensor control.
REQ-009 alert_p_o, alert_n_o  out  1 each  differential alert request pair to sensor control.
REQ-010 busy_o  out  1  high whenever state is not Idle.
REQ-011 event_cnt_o  out  CntW  saturating count of alerts raised.

Function
REQ-012 trig_act = trig_p_i | ~trig_n_i, so either rail alone triggers; ack_act = ack_p_i | ~ack_n_i.
REQ-013 src = event_i | trig_act.
REQ-014 Debounce counter: +1 per cycle src=1, saturates at DebounceCnt; cleared to 0 in any cycle src=0.
REQ-015 qual = (counter == DebounceCnt), registered value.
REQ-016 FSM states: Idle, Assert, AckWait.
REQ-017 Idle -> Assert when qual=1; event_cnt_o increments on this transition, saturating at 2^CntW-1.
REQ-018 Assert: alert_p_o=1, alert_n_o=0; stays in Assert until ack_act=1, then -> AckWait.
REQ-019 AckWait: alert_p_o=0, alert_n_o=1; -> Idle in the first cycle ack_act=0.
REQ-020 A qualified event arriving while in Assert or AckWait SHALL be merged, not queued, and SHALL not increment event_cnt_o.
REQ-021 If src stays high, the source SHALL re-enter Assert on the cycle after returning to Idle, so a persistent event re-fires continuously.
REQ-022 ack_act while in Idle SHALL be ignored.
REQ-023 Latency: event_i rising to alert_p_o rising SHALL be DebounceCnt+1 cycles.
REQ-024 alert outputs SHALL be driven directly from flops, with no combinational path from any input.

Reset
REQ-025 In reset: state Idle, counter 0, alert_p_o=0, alert_n_o=1, busy_o=0, event_cnt_o=0.
REQ-026 Reset asserted mid-Assert or mid-AckWait SHALL return the outputs to their reset values at the next clock edge, with no ack required.
REQ-027 The first qualification after reset release SHALL require a full DebounceCnt cycles of src.

Configuration
REQ-028 Macro AST_ALERT_SRC_SKEW_EN.
- When defined: alert_n_o SHALL lag alert_p_o by exactly one cycle on every transition, including the reset release value.
- When undefined: both rails SHALL switch in the same cycle.
- REQ-018 and REQ-019 state the undefined case.

Structure
REQ-029 State enum type ast_alert_src_state_e and the default DebounceCnt constant SHALL live in ast_pkg.
REQ-030 The debounce counter and qual logic SHALL be the sub-module ast_alert_debounce; the FSM, counter and output flops stay in the top level.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- event_i high 2 cycles with DebounceCnt=3 -> no alert; event_cnt_o stays 0.
- event_i held high, ack_p_i pulsed 2 cycles after alert_p_o rises -> alert_p_o high at cycle 4, drops the cycle after ack, re-asserts after one AckWait cycle; event_cnt_o=2 after the second raise.
- trig_n_i=0 with trig_p_i=0, single-rail trigger -> alert raised after 4 cycles; ack via ack_n_i=0 alone is accepted.
- rst_i pulsed 1 cycle while in Assert -> next cycle alert_p_o=0, alert_n_o=1, busy_o=0, event_cnt_o=0.
- 300 raise/ack cycles with CntW=8 -> event_cnt_o saturates at 255.
- With AST_ALERT_SRC_SKEW_EN defined -> alert_n_o falls exactly one cycle after alert_p_o rises, and rises one cycle after alert_p_o falls.
